cpu_control: RTL and testbench

Multicycle control unit for the CPU. It sits directly upstream of the datapath. It decodes the 6-bit opcode held in the instruction register and sequences a Moore FSM of up to 5 states per instruction. It drives every datapath control strobe plus the `state`/`next_state` debug buses, stalls on memory via a ready handshake, and counts retired instructions.

---
 rtl/cpu_ctrl_pkg.sv | 56 +++++
 rtl/cpu_ctrl_decode.sv | 41 ++++
 rtl/cpu_control.sv | 201 ++++++++++++++++++++
 tb/tb_cpu_control.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multicycle CPU control unit: FSM state
// encodings, opcode constants/class fields, ALU codes and mux encodings.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WB   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_ALU_WB   = 4'd10,
        S_LUI_WB   = 4'd11
    } state_t;

    typedef enum logic [3:0] {
        CLS_R       = 4'd0,
        CLS_I       = 4'd1,
        CLS_LW      = 4'd2,
        CLS_SW      = 4'd3,
        CLS_LUI     = 4'd4,
        CLS_SWB     = 4'd5,
        CLS_BRANCH  = 4'd6,
        CLS_J       = 4'd7,
        CLS_ILLEGAL = 4'd8
    } op_class_t;

    // Class prefix fields (upper opcode bits)
    localparam logic [1:0] OPC_R  = 2'b00;
    localparam logic [1:0] OPC_I  = 2'b01;
    localparam logic [2:0] OPC_BR = 3'b110;

    // Fully decoded opcodes
    localparam logic [5:0] OP_LW  = 6'b100000;
    localparam logic [5:0] OP_SW  = 6'b100001;
    localparam logic [5:0] OP_LUI = 6'b100010;
    localparam logic [5:0] OP_SWB = 6'b100011;
    localparam logic [5:0] OP_J   = 6'b111000;

    localparam logic [3:0] ALU_ADD = 4'h2;
    localparam logic [3:0] ALU_SUB = 4'h6;

    localparam logic [1:0] SRCB_REGB = 2'd0;
    localparam logic [1:0] SRCB_FOUR = 2'd1;
    localparam logic [1:0] SRCB_SIMM = 2'd2;
    localparam logic [1:0] SRCB_ZIMM = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Combinational opcode decoder: instruction class, ALU function for the
// execute step, immediate-extension select for I-type and branch compare type.
module cpu_ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    output logic [3:0] op_class,
    output logic [3:0] alu_op,
    output logic [1:0] alu_src_b,
    output logic [2:0] branch_type
);

    // I-type ops with op[3]=1 are the logical group and take a zero-extended imm
    assign alu_src_b   = opcode[3] ? SRCB_ZIMM : SRCB_SIMM;
    assign branch_type = opcode[2:0];

    // Classify the opcode; anything not matched stays illegal
    always_comb begin
        op_class = CLS_ILLEGAL;
        alu_op   = ALU_ADD;
        if (opcode[5:4] == OPC_R) begin
            op_class = CLS_R;
            alu_op   = opcode[3:0];
        end else if (opcode[5:4] == OPC_I) begin
            op_class = CLS_I;
            alu_op   = opcode[3:0];
        end else if (opcode[5:3] == OPC_BR) begin
            op_class = CLS_BRANCH;
        end else begin
            case (opcode)
                OP_LW:   op_class = CLS_LW;
                OP_SW:   op_class = CLS_SW;
                OP_LUI:  op_class = CLS_LUI;
                OP_SWB:  op_class = CLS_SWB;
                OP_J:    op_class = CLS_J;
                default: op_class = CLS_ILLEGAL;
            endcase
        end
    end

endmodule

// File: rtl/cpu_control.sv
// Multicycle CPU control unit: Moore FSM sequencing the datapath strobes,
// memory ready stalls and a wrapping retired-instruction counter.
//
// state      | meaning
// FETCH      | read instruction, PC+4; waits on mem_ready
// DECODE     | precompute branch target, dispatch on opcode class
// EXEC_R     | ALU regA op regB
// EXEC_I     | ALU regA op imm (sign/zero extended)
// MEM_ADDR   | effective address regA + simm
// MEM_RD     | load access; waits on mem_ready
// MEM_WB     | write loaded data to rt
// MEM_WR     | store access; waits on mem_ready
// BRANCH     | compare regA - regB, conditional PC load
// JUMP       | PC <- jump target
// ALU_WB     | write ALU result to rd (R) or rt (I)
// LUI_WB     | write upper immediate to rt
module cpu_control
    import cpu_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic [3:0]       state,
    output logic [3:0]       next_state,
    output logic             PCWrite,
    output logic             Branch,
    output logic [2:0]       BranchType,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic [1:0]       PCSource,
    output logic [3:0]       ALUOp,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic             LUI,
    output logic             SWB,
    output logic             instr_done,
    output logic             illegal,
    output logic [CNT_W-1:0] retired_count
);

    state_t           state_q;
    state_t           nxt;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       op_class;
    logic [3:0]       dec_alu_op;
    logic [1:0]       dec_src_b;
    logic [2:0]       dec_branch_type;

    cpu_ctrl_decode u_decode (
        .opcode      (opcode),
        .op_class    (op_class),
        .alu_op      (dec_alu_op),
        .alu_src_b   (dec_src_b),
        .branch_type (dec_branch_type)
    );

    // Reset is reflected combinationally so the debug buses read FETCH
    // from the very first cycle reset is high, not one cycle later.
    assign state         = reset ? S_FETCH : state_q;
    assign next_state    = nxt;
    assign retired_count = reset ? '0 : cnt_q;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= nxt;
    end

    // Next-state logic
    always_comb begin
        nxt = S_FETCH;
        if (!reset) begin
            case (state_q)
                S_FETCH:    nxt = mem_ready ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    case (op_class)
                        CLS_R:                   nxt = S_EXEC_R;
                        CLS_I:                   nxt = S_EXEC_I;
                        CLS_LW, CLS_SW, CLS_SWB: nxt = S_MEM_ADDR;
                        CLS_LUI:                 nxt = S_LUI_WB;
                        CLS_BRANCH:              nxt = S_BRANCH;
                        CLS_J:                   nxt = S_JUMP;
                        default:                 nxt = S_FETCH;
                    endcase
                end
                S_EXEC_R:   nxt = S_ALU_WB;
                S_EXEC_I:   nxt = S_ALU_WB;
                S_MEM_ADDR: nxt = (op_class == CLS_LW) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD:   nxt = mem_ready ? S_MEM_WB : S_MEM_RD;
                S_MEM_WR:   nxt = mem_ready ? S_FETCH : S_MEM_WR;
                default:    nxt = S_FETCH;
            endcase
        end
    end

    // Output decode from state (plus mem_ready in the waiting states)
    always_comb begin
        PCWrite    = 1'b0;
        Branch     = 1'b0;
        BranchType = 3'd0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        MemtoReg   = 1'b0;
        RegDst     = 1'b0;
        RegWrite   = 1'b0;
        PCSource   = PCSRC_ALU;
        ALUOp      = 4'd0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_REGB;
        LUI        = 1'b0;
        SWB        = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    MemRead  = 1'b1;
                    ALUSrcB  = SRCB_FOUR;
                    ALUOp    = ALU_ADD;
                    PCSource = PCSRC_ALU;
                    IRWrite  = mem_ready;
                    PCWrite  = mem_ready;
                end
                S_DECODE: begin
                    ALUSrcB = SRCB_SIMM;
                    ALUOp   = ALU_ADD;
                    illegal = (op_class == CLS_ILLEGAL);
                end
                S_EXEC_R: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_REGB;
                    ALUOp   = dec_alu_op;
                end
                S_EXEC_I: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = dec_src_b;
                    ALUOp   = dec_alu_op;
                end
                S_MEM_ADDR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_SIMM;
                    ALUOp   = ALU_ADD;
                    SWB     = (op_class == CLS_SWB);
                end
                S_MEM_RD: begin
                    MemRead = 1'b1;
                end
                S_MEM_WB: begin
                    RegWrite   = 1'b1;
                    MemtoReg   = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEM_WR: begin
                    MemWrite   = 1'b1;
                    SWB        = (op_class == CLS_SWB);
                    instr_done = mem_ready;
                end
                S_BRANCH: begin
                    ALUSrcA    = 1'b1;
                    ALUSrcB    = SRCB_REGB;
                    ALUOp      = ALU_SUB;
                    Branch     = 1'b1;
                    BranchType = dec_branch_type;
                    PCSource   = PCSRC_ALUOUT;
                    instr_done = 1'b1;
                end
                S_JUMP: begin
                    PCWrite    = 1'b1;
                    PCSource   = PCSRC_JUMP;
                    instr_done = 1'b1;
                end
                S_ALU_WB: begin
                    RegWrite   = 1'b1;
                    RegDst     = (op_class == CLS_R);
                    instr_done = 1'b1;
                end
                S_LUI_WB: begin
                    LUI        = 1'b1;
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk) begin
        if (reset)           cnt_q <= '0;
        else if (instr_done) cnt_q <= cnt_q + CNT_W'(1);
    end

endmodule

// File: tb/tb_cpu_control.sv
// Self-checking bench for cpu_control: instruction-level reference model
// (per-opcode phase lists) checked every cycle, a table of per-opcode cycle
// counts, directed corner sequences and a randomized run.
module tb_cpu_control;

    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [5:0]    opcode = 6'd0;
    logic          mem_ready = 1'b0;
    logic [3:0]    state, next_state, ALUOp;
    logic          PCWrite, Branch, MemRead, MemWrite, IRWrite, MemtoReg;
    logic          RegDst, RegWrite, ALUSrcA, LUI, SWB, instr_done, illegal;
    logic [2:0]    BranchType;
    logic [1:0]    PCSource, ALUSrcB;
    logic [CW-1:0] retired_count;

    always #5 clk = ~clk;

    cpu_control #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .state(state), .next_state(next_state), .PCWrite(PCWrite),
        .Branch(Branch), .BranchType(BranchType), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
        .RegDst(RegDst), .RegWrite(RegWrite), .PCSource(PCSource),
        .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .LUI(LUI),
        .SWB(SWB), .instr_done(instr_done), .illegal(illegal),
        .retired_count(retired_count)
    );

    typedef struct packed {
        logic [3:0] st;
        logic [3:0] nx;
        logic       pcw;
        logic       br;
        logic [2:0] bt;
        logic       mr;
        logic       mw;
        logic       irw;
        logic       m2r;
        logic       rd;
        logic       rw;
        logic [1:0] pcs;
        logic [3:0] aop;
        logic       asa;
        logic [1:0] asb;
        logic       lui;
        logic       swb;
        logic       done;
        logic       ill;
    } obs_t;

    typedef struct {
        logic [5:0] op;
        int         cyc;
        int         ret;
    } vec_t;

    int            n_cmp = 0;
    int            n_bad = 0;
    int            seq[$];
    bit            m_ret;
    logic [CW-1:0] m_cnt = '0;
    obs_t          a_obs;

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Phase list of an instruction, phases named by the state numbers
    function automatic void load_path(input logic [5:0] op);
        m_ret = 1'b1;
        if (op[5:4] == 2'b00)                        seq = '{0, 1, 2, 10};
        else if (op[5:4] == 2'b01)                   seq = '{0, 1, 3, 10};
        else if (op == 6'b100000)                    seq = '{0, 1, 4, 5, 6};
        else if (op == 6'b100001 || op == 6'b100011) seq = '{0, 1, 4, 7};
        else if (op == 6'b100010)                    seq = '{0, 1, 11};
        else if (op[5:3] == 3'b110)                  seq = '{0, 1, 8};
        else if (op == 6'b111000)                    seq = '{0, 1, 9};
        else begin
            seq   = '{0, 1};
            m_ret = 1'b0;
        end
    endfunction

    function automatic obs_t phase_obs(input int ph, input logic [5:0] op, input logic rdy);
        obs_t o = '0;
        o.st = 4'(ph);
        case (ph)
            0:  begin o.mr = 1; o.asb = 2'd1; o.aop = 4'h2; o.irw = rdy; o.pcw = rdy; end
            1:  begin o.asb = 2'd2; o.aop = 4'h2; end
            2:  begin o.asa = 1; o.aop = op[3:0]; end
            3:  begin o.asa = 1; o.asb = op[3] ? 2'd3 : 2'd2; o.aop = op[3:0]; end
            4:  begin o.asa = 1; o.asb = 2'd2; o.aop = 4'h2; o.swb = (op == 6'b100011); end
            5:  o.mr = 1;
            6:  begin o.rw = 1; o.m2r = 1; end
            7:  begin o.mw = 1; o.swb = (op == 6'b100011); end
            8:  begin o.asa = 1; o.aop = 4'h6; o.br = 1; o.pcs = 2'd1; o.bt = op[2:0]; end
            9:  begin o.pcw = 1; o.pcs = 2'd2; end
            10: begin o.rw = 1; o.rd = (op[5:4] == 2'b00); end
            11: begin o.lui = 1; o.rw = 1; end
            default: ;
        endcase
        return o;
    endfunction

    // One clock: drive at negedge, compare before the rising edge, advance model after it
    task automatic tick(input logic [5:0] op, input logic rdy, input logic rst);
        obs_t e;
        int   ph;
        bit   stall, last;
        @(negedge clk);
        reset     = rst;
        mem_ready = rdy;
        if (!rst && seq.size() == 0) begin
            opcode = op;
            load_path(op);
        end
        #1;
        a_obs = {state, next_state, PCWrite, Branch, BranchType, MemRead, MemWrite,
                 IRWrite, MemtoReg, RegDst, RegWrite, PCSource, ALUOp, ALUSrcA,
                 ALUSrcB, LUI, SWB, instr_done, illegal};
        stall = 1'b0;
        last  = 1'b0;
        if (rst) begin
            e = '0;
        end else begin
            ph     = seq[0];
            stall  = (ph == 0 || ph == 5 || ph == 7) && !rdy;
            last   = (seq.size() == 1);
            e      = phase_obs(ph, opcode, rdy);
            e.nx   = stall ? 4'(ph) : (last ? 4'd0 : 4'(seq[1]));
            e.done = last && !stall && m_ret;
            e.ill  = last && !m_ret;
        end
        check_val("outputs", 32'(a_obs), 32'(e));
        check_val("retired_count", 32'(retired_count), rst ? 32'd0 : 32'(m_cnt));
        @(posedge clk);
        if (rst) begin
            seq.delete();
            m_cnt = '0;
        end else if (!stall) begin
            if (last && m_ret) m_cnt = m_cnt + 1'b1;
            void'(seq.pop_front());
        end
    endtask

    initial begin
        vec_t          vt[11];
        int            exp_st[8];
        logic          rdy_pat[8];
        int            n, k, nrd;
        logic [CW-1:0] cnt0;

        vt[0]  = '{6'b000010, 4, 1};
        vt[1]  = '{6'b011010, 4, 1};
        vt[2]  = '{6'b010001, 4, 1};
        vt[3]  = '{6'b100000, 5, 1};
        vt[4]  = '{6'b100001, 4, 1};
        vt[5]  = '{6'b100011, 4, 1};
        vt[6]  = '{6'b100010, 3, 1};
        vt[7]  = '{6'b110101, 3, 1};
        vt[8]  = '{6'b111000, 3, 1};
        vt[9]  = '{6'b100111, 2, 0};
        vt[10] = '{6'b111111, 2, 0};

        // Reset release into an R-type: states 0,1,2,10
        tick(6'd0, 1'b1, 1'b1);
        tick(6'd0, 1'b1, 1'b1);
        exp_st[0:3] = '{0, 1, 2, 10};
        for (int i = 0; i < 4; i++) begin
            tick(6'b000010, 1'b1, 1'b0);
            check_val("r_state", 32'(a_obs.st), 32'(exp_st[i]));
        end
        check_val("r_regwrite_regdst", {30'd0, a_obs.rw, a_obs.rd}, 32'd3);
        #1 check_val("r_count", 32'(retired_count), 32'd1);

        // LW with three memory wait cycles in MEM_RD
        exp_st  = '{0, 1, 4, 5, 5, 5, 5, 6};
        rdy_pat = '{1, 1, 1, 0, 0, 0, 1, 1};
        nrd = 0;
        for (int i = 0; i < 8; i++) begin
            tick(6'b100000, rdy_pat[i], 1'b0);
            check_val("lw_state", 32'(a_obs.st), 32'(exp_st[i]));
            if (a_obs.st == 4'd5 && a_obs.mr) nrd++;
        end
        check_val("lw_memrd_cycles", 32'(nrd), 32'd4);
        check_val("lw_memtoreg_done", {30'd0, a_obs.m2r, a_obs.done}, 32'd3);

        // Branch 110011
        for (int i = 0; i < 3; i++) tick(6'b110011, 1'b1, 1'b0);
        check_val("br_state", 32'(a_obs.st), 32'd8);
        check_val("br_fields", {20'd0, a_obs.br, a_obs.bt, a_obs.pcs, a_obs.aop, a_obs.nx},
                  {20'd0, 1'b1, 3'd3, 2'd1, 4'h6, 4'd0});

        // Illegal 101111
        cnt0 = m_cnt;
        tick(6'b101111, 1'b1, 1'b0);
        tick(6'b101111, 1'b1, 1'b0);
        check_val("ill_pulse", {28'd0, a_obs.ill, a_obs.rw, a_obs.mw, a_obs.done}, 32'h8);
        check_val("ill_next", 32'(a_obs.nx), 32'd0);
        #1 check_val("ill_count", 32'(retired_count), 32'(cnt0));

        // Reset while MEM_WR waits on memory
        tick(6'b100001, 1'b1, 1'b0);
        tick(6'b100001, 1'b1, 1'b0);
        tick(6'b100001, 1'b1, 1'b0);
        tick(6'b100001, 1'b0, 1'b0);
        tick(6'b100001, 1'b0, 1'b0);
        check_val("sw_wait", {30'd0, a_obs.st == 4'd7, a_obs.mw}, 32'd3);
        tick(6'b100001, 1'b0, 1'b1);
        check_val("rst_memwr", {24'd0, a_obs.st, 3'd0, a_obs.mw}, 32'd0);
        check_val("rst_count", 32'(retired_count), 32'd0);

        // Counter wrap on a J
        k = 0;
        while (m_cnt != '1 && k < 400) begin
            for (int i = 0; i < 3; i++) tick(6'b111000, 1'b1, 1'b0);
            k++;
        end
        check_val("wrap_reach_max", 32'(k < 400), 32'd1);
        for (int i = 0; i < 3; i++) tick(6'b111000, 1'b1, 1'b0);
        check_val("j_fields", {29'd0, a_obs.pcw, a_obs.pcs}, 32'b110);
        #1 check_val("wrap_count", 32'(retired_count), 32'd0);

        // Per-opcode cycle counts with memory always ready
        foreach (vt[i]) begin
            cnt0 = m_cnt;
            n = 0;
            do begin
                tick(vt[i].op, 1'b1, 1'b0);
                n++;
            end while (!(a_obs.done || a_obs.ill) && n < 12);
            check_val("table_cycles", 32'(n), 32'(vt[i].cyc));
            #1 check_val("table_retired", 32'(retired_count), 32'(cnt0 + CW'(vt[i].ret)));
        end

        // Randomized instructions, memory stalls and occasional resets
        for (int i = 0; i < 3000; i++) begin
            tick(6'($urandom_range(0, 63)), $urandom_range(0, 9) < 7,
                 $urandom_range(0, 199) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
